// File: rtl/aha_ahb_to_sram32k.sv
// AHB-Lite slave bridging to a single-port synchronous 32-bit SRAM.
// Zero wait states. A write's data phase can collide with a read's address phase.
// In that case the read gets the port, and the write is parked in a one-entry buffer.
// Reads that hit the parked write are forwarded from the buffer, byte by byte.
module aha_ahb_to_sram32k #(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  SRAM_CEn,
  output logic [3:0]            SRAM_WEn,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [31:0]           SRAM_D,
  input  logic [31:0]           SRAM_Q
);

  logic                  trans_valid;
  logic                  rd_req;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_lanes;

  // Write data phase state
  logic                  wdp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [3:0]            wlanes_q;

  // Read data phase state
  logic                  rdp_q;
  logic [ADDR_WIDTH-1:0] raddr_q;

  // Parked write
  logic                  buf_pend_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [3:0]            buf_lanes_q;
  logic [31:0]           buf_data_q;

  logic                  wr_direct;
  logic                  buf_commit;
  logic                  buf_capture;
  logic                  fwd_hit;

  // Upper address bits alias; HTRANS[0] only separates NONSEQ from SEQ.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign trans_valid = HSEL & HREADY & HTRANS[1];
  assign rd_req      = trans_valid & ~HWRITE;
  assign wr_req      = trans_valid & HWRITE;
  assign req_addr    = HADDR[ADDR_WIDTH+1:2];

  // SRAM port priority: read address phase, then live write data, then parked write.
  assign wr_direct   = wdp_q & ~rd_req;
  assign buf_commit  = buf_pend_q & ~rd_req & ~wdp_q;
  assign buf_capture = wdp_q & rd_req;
  assign fwd_hit     = buf_pend_q & (buf_addr_q == raddr_q);

  // Little-endian byte-lane decode from size and low address bits
  always_comb begin
    req_lanes = 4'b0000;
    if (HSIZE[2] | HSIZE[1]) begin
      req_lanes = 4'b1111;
    end else if (HSIZE[0]) begin
      req_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
    end else begin
      req_lanes = 4'b0001 << HADDR[1:0];
    end
  end

  // Write address phase registers; wdp lasts exactly one cycle
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wdp_q    <= 1'b0;
      waddr_q  <= '0;
      wlanes_q <= 4'b0000;
    end else begin
      wdp_q <= wr_req;
      if (wr_req) begin
        waddr_q  <= req_addr;
        wlanes_q <= req_lanes;
      end
    end
  end

  // Read address phase registers for the one-cycle-later data phase
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rdp_q   <= 1'b0;
      raddr_q <= '0;
    end else begin
      rdp_q <= rd_req;
      if (rd_req) begin
        raddr_q <= req_addr;
      end
    end
  end

  // Park a write that lost the port to a read; release once it reaches the SRAM
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      buf_pend_q  <= 1'b0;
      buf_addr_q  <= '0;
      buf_lanes_q <= 4'b0000;
      buf_data_q  <= '0;
    end else if (buf_capture) begin
      buf_pend_q  <= 1'b1;
      buf_addr_q  <= waddr_q;
      buf_lanes_q <= wlanes_q;
      buf_data_q  <= HWDATA;
    end else if (buf_commit) begin
      buf_pend_q <= 1'b0;
    end
  end

  // SRAM port drive according to the priority above
  always_comb begin
    SRAM_CEn = 1'b1;
    SRAM_WEn = 4'hF;
    SRAM_A   = buf_addr_q;
    SRAM_D   = buf_data_q;
    if (rd_req) begin
      SRAM_CEn = 1'b0;
      SRAM_A   = req_addr;
    end else if (wr_direct) begin
      SRAM_CEn = 1'b0;
      SRAM_WEn = ~wlanes_q;
      SRAM_A   = waddr_q;
      SRAM_D   = HWDATA;
    end else if (buf_pend_q) begin
      SRAM_CEn = 1'b0;
      SRAM_WEn = ~buf_lanes_q;
    end
  end

  // Read data, with per-lane forwarding from a parked write to the same word
  always_comb begin
    HRDATA = '0;
    if (rdp_q) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (fwd_hit && buf_lanes_q[i]) ? buf_data_q[8*i +: 8]
                                                        : SRAM_Q[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/aha_ahb_to_sram32k.md
AHA_AHB_TO_SRAM32K -- requirements
Module: aha_ahb_to_sram32k

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning SRAM word-address width; the byte-addressed window is 2^(ADDR_WIDTH+2) bytes.
- REQ-002 SHALL have one clock and an asynchronous active-low reset, with ports named CLK and RESETn.
- REQ-003 SHALL have port CLK, input, 1, rising-edge clock for all state.
- REQ-004 SHALL have port RESETn, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port HSEL, input, 1, AHB-Lite slave select.
- REQ-006 SHALL have port HADDR, input, 32, byte address; only [ADDR_WIDTH+1:0] is used.
- REQ-007 SHALL have port HTRANS, input, 2, transfer type.
- REQ-008 SHALL have port HSIZE, input, 3, transfer size.
- REQ-009 SHALL have port HWRITE, input, 1, 1 = write.
- REQ-010 SHALL have port HREADY, input, 1, bus ready.
- REQ-011 SHALL have port HWDATA, input, 32, write data, valid in the data phase.
- REQ-012 SHALL have port HREADYOUT, output, 1, slave ready.
- REQ-013 SHALL have port HRESP, output, 1, response.
- REQ-014 SHALL have port HRDATA, output, 32, read data.
- REQ-015 SHALL have port SRAM_CEn, output, 1, SRAM chip enable, active low.
- REQ-016 SHALL have port SRAM_WEn, output, 4, per-byte write enable, active low.
- REQ-017 SHALL have port SRAM_A, output, ADDR_WIDTH, SRAM word address.
- REQ-018 SHALL have port SRAM_D, output, 32, SRAM write data.
- REQ-019 SHALL have port SRAM_Q, input, 32, SRAM read data, valid the cycle after a read access.

Function
- REQ-020 SHALL treat a transfer as valid when HSEL & HREADY & HTRANS[1]; IDLE and BUSY SHALL cause no access.
- REQ-021 SHALL tie HREADYOUT=1 (zero wait states) and HRESP=0 (OKAY) permanently.
- REQ-022 SHALL derive lanes little-endian: byte -> lane HADDR[1:0]; half -> lanes {1,0} or {3,2} by HADDR[1]; HSIZE>=2 -> all four lanes.
- REQ-023 SHALL set word address to HADDR[ADDR_WIDTH+1:2] and ignore higher bits (aliasing).
- REQ-024 SHALL, on a valid write address phase, register address and lanes and set write-data-phase flag wdp for exactly the next cycle.
- REQ-025 SHALL arbitrate the SRAM port each cycle in this priority: (1) valid read address phase -> read at HADDR word (CEn=0, WEn=4'hF); (2) else wdp -> write HWDATA directly to the registered address and lanes; (3) else buf_pend -> write buffer contents; (4) else idle (CEn=1, WEn=4'hF).
- REQ-026 SHALL, when wdp and a read address phase coincide, capture {address, lanes, HWDATA} into a one-entry buffer and set buf_pend at that edge.
- REQ-027 SHALL clear buf_pend at the edge ending a cycle in which case (3) executed.
- REQ-028 SHALL never require a second buffer entry; the bench SHALL assert that wdp with read priority never occurs while buf_pend=1.
- REQ-029 SHALL register the read word address for a read address phase and drive HRDATA in the following cycle (one-cycle latency).
- REQ-030 SHALL drive each HRDATA byte lane i from buf_data when buf_pend and buf_addr equals the registered read address and buf_lanes[i], else from SRAM_Q.
- REQ-031 SHALL drive HRDATA=0 outside read data phases.
- REQ-032 SHALL drive SRAM_D from HWDATA in case (2) and from buf_data otherwise.
- REQ-033 SHALL make a read of a word written in the immediately preceding address phase return the new data for written lanes and the old SRAM data for unwritten lanes.

Reset
- REQ-034 SHALL asynchronously clear wdp, buf_pend, buffer registers and the read-data-phase flag while RESETn=0, with SRAM_CEn=1, SRAM_WEn=4'hF, HRDATA=0, HREADYOUT=1 and HRESP=0.
- REQ-035 SHALL discard a pending buffered write on reset mid-operation, so the SRAM retains its prior content for that write.

Verification
- REQ-036 SHALL cover: word write 0xDEADBEEF @0x100, idle, read @0x100 -> SRAM write in write data phase; HRDATA=0xDEADBEEF one cycle after the read address phase.
- REQ-037 SHALL cover: byte write 0xAB @0x103 back-to-back with word read @0x100, SRAM word 0x11223344 -> buf_pend=1; HRDATA=0xAB223344; buffer committed at the next non-read cycle.
- REQ-038 SHALL cover: halfword write 0x5566 @0x202, read @0x200, read @0x204, idle -> buffer held across both reads, committed in the idle cycle; a later read @0x200 returns the merged word.
- REQ-039 SHALL cover: HTRANS=BUSY or HSEL=0 with HWRITE=1 -> SRAM_CEn stays 1 and there is no state change.
- REQ-040 SHALL cover: RESETn low while buf_pend=1 -> buffer dropped, outputs at reset values, and a following read returns the old SRAM data.
- REQ-041 SHALL cover: random back-to-back R/W traffic against a reference memory model -> every HRDATA matches the model and HREADYOUT is always 1.
